// File: rtl/operand_pkg.sv
// -----------------------------------------------------------------------------
// operand_pkg
// Shared constants, FSM state codes, operation modes and operand helper
// functions for the operand_datapath responder.
// Configuration macro: OPERAND_SIGNED_EN (operands are two's complement when
// defined, unsigned zero-extended otherwise).
// -----------------------------------------------------------------------------
package operand_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int ADDR_W = 9;

   // FSM state codes
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_CAPT  = 3'd2;
   localparam logic [2:0] ST_MUL   = 3'd3;
   localparam logic [2:0] ST_DIV   = 3'd4;
   localparam logic [2:0] ST_STORE = 3'd5;

   // Request index; lower index wins arbitration
   localparam logic [1:0] SVC_A = 2'd0;
   localparam logic [1:0] SVC_B = 2'd1;
   localparam logic [1:0] SVC_R = 2'd2;
   localparam logic [1:0] SVC_C = 2'd3;

   typedef enum logic [1:0] {
      MODE_ADD = 2'd0,
      MODE_SUB = 2'd1,
      MODE_MUL = 2'd2,
      MODE_DIV = 2'd3
   } mode_t;

   // Widen a ROM operand to accumulator width
   function automatic logic [ACC_W-1:0] ext_operand(input logic [DATA_W-1:0] v);
`ifdef OPERAND_SIGNED_EN
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
`else
      return {{(ACC_W-DATA_W){1'b0}}, v};
`endif
   endfunction

   // Magnitude of a value whose sign is supplied separately
   function automatic logic [ACC_W-1:0] mag(input logic [ACC_W-1:0] v, input logic neg);
      return neg ? ({ACC_W{1'b0}} - v) : v;
   endfunction

endpackage

// File: rtl/operand_seq_engine.sv
// -----------------------------------------------------------------------------
// operand_seq_engine
// Arithmetic engine: single-cycle add/subtract, iterative multiply (repeated
// addition) and divide (repeated subtraction).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, mode     load operands and begin the selected operation
//   opa, opb        A and B operands (DATA_W)
//   acc             accumulator / running dividend / remainder (ACC_W)
//   quot            quotient of the last division (ACC_W)
//   busy            an iterative operation is in progress
//   fin             combinational: this cycle is the last iteration
//   div_zero        last division had B = 0
// Configuration macro: OPERAND_SIGNED_EN (sign-magnitude handling of MUL/DIV).
// -----------------------------------------------------------------------------
module operand_seq_engine
   import operand_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic [ACC_W-1:0]  acc,
   output logic [ACC_W-1:0]  quot,
   output logic              busy,
   output logic              fin,
   output logic              div_zero
);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] quot_r;
   logic [ACC_W-1:0] opnd_r;      // addend for MUL, divisor magnitude for DIV
   logic [ACC_W-1:0] cnt_r;
   logic [1:0]       mode_r;
   logic             busy_r;
   logic             div_zero_r;
   logic             neg_res_r;   // negate product / quotient at the end
   logic             neg_rem_r;   // negate remainder at the end
   logic [ACC_W-1:0] ea_s;
   logic [ACC_W-1:0] eb_s;
   logic [ACC_W-1:0] sum_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic             fin_s;
   logic             b_zero_s;

   assign ea_s     = ext_operand(opa);
   assign eb_s     = ext_operand(opb);
   assign sum_s    = acc_r + opnd_r;
   assign b_zero_s = (opb == {DATA_W{1'b0}});

`ifdef OPERAND_SIGNED_EN
   assign a_neg_s = opa[DATA_W-1];
   assign b_neg_s = opb[DATA_W-1];
`else
   assign a_neg_s = 1'b0;
   assign b_neg_s = 1'b0;
`endif

   // Detect the final iteration of the running operation
   always_comb begin
      fin_s = 1'b0;
      if (busy_r) begin
         case (mode_r)
            MODE_MUL: fin_s = (cnt_r == 16'd1);
            MODE_DIV: fin_s = (acc_r < opnd_r);
            default:  fin_s = 1'b1;
         endcase
      end else begin
         fin_s = 1'b0;
      end
   end

   // Operand load and iteration
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_r      <= 16'd0;
         quot_r     <= 16'd0;
         opnd_r     <= 16'd0;
         cnt_r      <= 16'd0;
         mode_r     <= MODE_ADD;
         busy_r     <= 1'b0;
         div_zero_r <= 1'b0;
         neg_res_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
      end else if (start) begin
         mode_r <= mode;
         case (mode)
            MODE_ADD: begin
               acc_r  <= ea_s + eb_s;
               busy_r <= 1'b0;
            end
            MODE_SUB: begin
               acc_r  <= ea_s - eb_s;
               busy_r <= 1'b0;
            end
            MODE_MUL: begin
               acc_r     <= 16'd0;
               opnd_r    <= ea_s;
               cnt_r     <= mag(eb_s, b_neg_s);
               neg_res_r <= b_neg_s;
               busy_r    <= !b_zero_s;
            end
            MODE_DIV: begin
               quot_r     <= 16'd0;
               div_zero_r <= b_zero_s;
               opnd_r     <= mag(eb_s, b_neg_s);
               neg_res_r  <= a_neg_s ^ b_neg_s;
               neg_rem_r  <= a_neg_s;
               if (b_zero_s) begin
                  // divide by zero: remainder is A as-is
                  acc_r  <= ea_s;
                  busy_r <= 1'b0;
               end else begin
                  acc_r  <= mag(ea_s, a_neg_s);
                  busy_r <= 1'b1;
               end
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end else if (busy_r) begin
         if (mode_r == MODE_MUL) begin
            cnt_r  <= cnt_r - 16'd1;
            busy_r <= !fin_s;
            if (fin_s && neg_res_r) begin
               acc_r <= 16'd0 - sum_s;
            end else begin
               acc_r <= sum_s;
            end
         end else begin
            if (fin_s) begin
               // leave DIV: apply result signs (no-op in the unsigned build)
               busy_r <= 1'b0;
               acc_r  <= neg_rem_r ? (16'd0 - acc_r) : acc_r;
               quot_r <= neg_res_r ? (16'd0 - quot_r) : quot_r;
            end else begin
               acc_r  <= acc_r - opnd_r;
               quot_r <= quot_r + 16'd1;
            end
         end
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign acc      = acc_r;
   assign quot     = quot_r;
   assign busy     = busy_r;
   assign fin      = fin_s;
   assign div_zero = div_zero_r;

endmodule

// File: rtl/operand_datapath.sv
// -----------------------------------------------------------------------------
// operand_datapath
// Responder side of the En/Fim handshake: detects request strobes, fetches
// A/B operands from a synchronous ROM, launches the arithmetic engine and
// stores result / remainder on request.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   EnA, EnB, EnC, EnResto              request levels (rising edge = request)
//   Endereco                            ROM address for A/B requests
//   Op, SELM, Div                       operation select, sampled at B capture
//   rom_addr / rom_data                 synchronous ROM port (1-cycle read)
//   FimA, FimB, FimC, FimResto          one-cycle completion pulses
//   B, Quociente, Resultado, Resto      operand B, running value, result, rest
//   div_zero                            last division had B = 0
// Configuration macro: OPERAND_SIGNED_EN (signed operands).
// -----------------------------------------------------------------------------
module operand_datapath
   import operand_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EnA,
   input  logic              EnB,
   input  logic              EnC,
   input  logic              EnResto,
   input  logic [ADDR_W-1:0] Endereco,
   input  logic              Op,
   input  logic              SELM,
   input  logic              Div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              FimA,
   output logic              FimB,
   output logic              FimC,
   output logic              FimResto,
   output logic [DATA_W-1:0] B,
   output logic [ACC_W-1:0]  Quociente,
   output logic [ACC_W-1:0]  Resultado,
   output logic [DATA_W-1:0] Resto,
   output logic              div_zero
);

   logic [2:0]        state_r;
   logic [1:0]        svc_r;
   logic [3:0]        en_s;         // {C, Resto, B, A}
   logic [3:0]        en_q_r;
   logic [3:0]        pend_r;
   logic [3:0]        req_s;
   logic [3:0]        grant_s;
   logic [ADDR_W-1:0] rom_addr_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [1:0]        mode_r;
   logic [1:0]        mode_s;
   logic              fim_a_r;
   logic              fim_b_r;
   logic              fim_c_r;
   logic              fim_r_r;
   logic [ACC_W-1:0]  resultado_r;
   logic [DATA_W-1:0] resto_r;
   logic              eng_start_s;
   logic [ACC_W-1:0]  eng_acc_s;
   logic [ACC_W-1:0]  eng_quot_s;
   logic              eng_busy_s;
   logic              eng_fin_s;
   logic              eng_dz_s;
   logic              b_zero_s;

   assign en_s     = {EnC, EnResto, EnB, EnA};
   // a fresh rising edge is serviceable in the same cycle it is seen
   assign req_s    = pend_r | (en_s & ~en_q_r);
   assign b_zero_s = (rom_data == {DATA_W{1'b0}});

   // Fixed-priority arbitration A > B > Resto > C, only while idle
   always_comb begin
      grant_s = 4'b0000;
      if (state_r == ST_IDLE) begin
         if (req_s[0]) begin
            grant_s = 4'b0001;
         end else if (req_s[1]) begin
            grant_s = 4'b0010;
         end else if (req_s[2]) begin
            grant_s = 4'b0100;
         end else if (req_s[3]) begin
            grant_s = 4'b1000;
         end else begin
            grant_s = 4'b0000;
         end
      end else begin
         grant_s = 4'b0000;
      end
   end

   // Operation decode from the select lines
   always_comb begin
      mode_s = MODE_SUB;
      if (Div) begin
         mode_s = MODE_DIV;
      end else if (SELM) begin
         mode_s = MODE_MUL;
      end else if (Op) begin
         mode_s = MODE_ADD;
      end else begin
         mode_s = MODE_SUB;
      end
   end

   assign eng_start_s = (state_r == ST_CAPT) && (svc_r == SVC_B);

   operand_seq_engine u_engine (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (eng_start_s),
      .mode     (mode_s),
      .opa      (a_r),
      .opb      (rom_data),
      .acc      (eng_acc_s),
      .quot     (eng_quot_s),
      .busy     (eng_busy_s),
      .fin      (eng_fin_s),
      .div_zero (eng_dz_s)
   );

   // Handshake FSM, pending flags, ROM fetch and stored outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         svc_r       <= SVC_A;
         // levels held through reset are not treated as new requests
         en_q_r      <= en_s;
         pend_r      <= 4'b0000;
         rom_addr_r  <= {ADDR_W{1'b0}};
         a_r         <= 8'd0;
         b_r         <= 8'd0;
         mode_r      <= MODE_ADD;
         fim_a_r     <= 1'b0;
         fim_b_r     <= 1'b0;
         fim_c_r     <= 1'b0;
         fim_r_r     <= 1'b0;
         resultado_r <= 16'd0;
         resto_r     <= 8'd0;
      end else begin
         en_q_r  <= en_s;
         pend_r  <= req_s & ~grant_s;
         fim_a_r <= 1'b0;
         fim_b_r <= 1'b0;
         fim_c_r <= 1'b0;
         fim_r_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s[0] || grant_s[1]) begin
                  rom_addr_r <= Endereco;
                  svc_r      <= grant_s[0] ? SVC_A : SVC_B;
                  state_r    <= ST_FETCH;
               end else if (grant_s[2] || grant_s[3]) begin
                  svc_r      <= grant_s[2] ? SVC_R : SVC_C;
                  state_r    <= ST_STORE;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               // ROM is reading rom_addr; data is valid during CAPT
               state_r <= ST_CAPT;
            end
            ST_CAPT: begin
               if (svc_r == SVC_A) begin
                  a_r     <= rom_data;
                  fim_a_r <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  b_r     <= rom_data;
                  fim_b_r <= 1'b1;
                  mode_r  <= mode_s;
                  // B = 0 never enters the iterative states
                  if ((mode_s == MODE_MUL) && !b_zero_s) begin
                     state_r <= ST_MUL;
                  end else if ((mode_s == MODE_DIV) && !b_zero_s) begin
                     state_r <= ST_DIV;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (eng_fin_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_STORE: begin
               if (svc_r == SVC_R) begin
                  resto_r <= eng_acc_s[DATA_W-1:0];
                  fim_r_r <= 1'b1;
               end else begin
                  resultado_r <= (mode_r == MODE_DIV) ? eng_quot_s : eng_acc_s;
                  fim_c_r     <= 1'b1;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = rom_addr_r;
   assign FimA      = fim_a_r;
   assign FimB      = fim_b_r;
   assign FimC      = fim_c_r;
   assign FimResto  = fim_r_r;
   assign B         = b_r;
   assign Quociente = eng_acc_s;
   assign Resultado = resultado_r;
   assign Resto     = resto_r;
   assign div_zero  = eng_dz_s;

endmodule

// File: doc/operand_datapath.md
# operand_datapath

Responder side of the controller's En/Fim handshake. Receives EnA/EnB/EnC/EnResto strobes and the ROM address from the sequencing controller, fetches operands from the synchronous operand ROM, and computes add, subtract, multiply (repeated addition) or divide (repeated subtraction). It answers each strobe with a one-cycle Fim pulse and presents the result, the remainder and the running dividend back to the controller.

## Interface
- DATA_W, 8, ROM word / operand width
- ACC_W, 16, accumulator/result width
- ADDR_W, 9, ROM address width
- clk  in  1  clock; all logic on posedge (controller uses negedge)
- rst_n  in  1  synchronous, active-low reset
- EnA, EnB, EnC, EnResto  in  1 each  request levels from controller
- Endereco  in  ADDR_W  ROM address for the current EnA/EnB request
- Op, SELM, Div  in  1 each  operation select, sampled at B capture
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr
- FimA, FimB, FimC, FimResto  out  1 each  completion pulses, one cycle wide
- B  out  DATA_W  captured B operand
- Quociente  out  ACC_W  running dividend / accumulator, used in the controller's compare
- Resultado  out  ACC_W  stored result
- Resto  out  DATA_W  stored remainder
- div_zero  out  1  last division had B = 0

## Operation
- Rising edges of the En inputs set pending flags. Service priority: A > B > Resto > C. One request in service at a time. Pending flags survive until serviced.
- FSM states: IDLE, FETCH, CAPT, MUL, DIV, STORE.
- A or B request, IDLE→FETCH→CAPT→IDLE:
  - FETCH: rom_addr <= Endereco.
  - CAPT: capture rom_data; pulse FimA or FimB.
- On B capture, the mode is decoded:
  - Div=1 → DIV: Quociente <= A, quot <= 0.
  - else SELM=1 → MUL: Quociente <= 0, cnt <= B.
  - else Op=1 → Quociente <= A+B.
  - else → Quociente <= A−B, 16-bit two's-complement wrap.
- MUL: each cycle Quociente += A, cnt−−. Exit to IDLE when cnt reaches 0. B=0 skips MUL and gives result 0. The 255×255 = 65025 product fits ACC_W with no overflow.
- DIV: each cycle, if Quociente ≥ B then Quociente −= B and quot++; else exit.
  - B=0: skip DIV, quot = 0, remainder = A, set div_zero.
- Resto request: if MUL/DIV is busy, hold it pending. Then Resto <= Quociente[DATA_W-1:0]; pulse FimResto.
- C request: if MUL/DIV is busy, hold it pending. STORE then writes Resultado:
  - quot for DIV.
  - Quociente for all other modes.
  - Pulse FimC.
- Reset (mid-operation included): next edge gives state IDLE and clears all pending flags, counters and outputs.

## Timing
- Reset values: every output 0, rom_addr 0.
- Latencies, counted from the posedge that samples the En rising edge:
  - FimA/FimB: high in the third cycle, i.e. 2-cycle latency (FETCH, CAPT).
  - FimC/FimResto: 1 cycle when not busy.
- MUL latency: B cycles. DIV latency: quot+1 cycles.
- Each Fim is exactly one posedge-to-posedge cycle wide, so the controller samples it on exactly one negedge.
- An En held high does not retrigger. A new request requires En low for at least one posedge.
- Simultaneous rising edges: the higher priority request is serviced first; the others are serviced back-to-back in later cycles.

## Configuration
- OPERAND_SIGNED_EN defined:
  - A and B are sign-extended to ACC_W.
  - MUL iterates |B| times and negates the result if B < 0.
  - DIV runs on magnitudes, truncates toward zero; quotient sign = sign(A)^sign(B); remainder takes the sign of A.
- OPERAND_SIGNED_EN undefined: operands zero-extended and unsigned; 255 means 255.

## Structure
- Package operand_pkg: state enum, DATA_W/ACC_W/ADDR_W constants, mode enum {ADD, SUB, MUL, DIV}.
- One sub-module, operand_seq_engine: the iterative MUL/DIV engine (accumulator, counter, busy/done). The top level keeps the handshake, pending flags and ROM fetch.

## Test plan
- A=7, B=5, Op=1 → FimA and FimB 2 cycles after each En; EnC → Resultado=12, FimC one cycle.
- A=3, B=9, Op=0 → Resultado=0xFFFA (unsigned build).
- A=255, B=255, SELM=1 → Resultado=65025 after 255 MUL cycles. B=0 → Resultado=0, no MUL cycles.
- A=100, B=7, Div=1 → Resultado=14, Resto=2. B=0 → Resultado=0, Resto=100, div_zero=1.
- EnC raised during MUL → held, FimC only after MUL completes. EnA and EnB rising in the same cycle → FimA before FimB.
- rst_n low mid-DIV → next cycle all outputs 0, state IDLE. With OPERAND_SIGNED_EN, A=−7 (0xF9), B=2, Div=1 → Resultado=−3, Resto=−1.
